// File: rtl/mux_sel_arb_if.sv
// Request/grant bundle between the two mux sources and mux_sel_arb.
// master = requesting side, slave = arbiter.
interface mux_sel_arb_if #(
  parameter int unsigned CW = 4
) ();
  logic          req_a;
  logic          req_b;
  logic          release_i;
  logic          sel;
  logic          gnt_a;
  logic          gnt_b;
  logic [CW-1:0] hold_cnt;
  logic [7:0]    switch_cnt;

  modport master (
    output req_a, req_b, release_i,
    input  sel, gnt_a, gnt_b, hold_cnt, switch_cnt
  );

  modport slave (
    input  req_a, req_b, release_i,
    output sel, gnt_a, gnt_b, hold_cnt, switch_cnt
  );
endinterface

// File: rtl/mux_sel_arb.sv
// Two-source round-robin arbiter driving the select of a downstream 2:1 mux.
// Define STICKY_SEL_EN to keep sel at its last granted value while idle.
module mux_sel_arb #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = 4
) (
  input logic          clk,
  input logic          rst,
  mux_sel_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

  localparam logic [CW-1:0] HoldMax = CW'(HOLD_MAX);

  state_e        state_q, state_d;
  logic          last_q, last_d;  // 1 = b was granted last
  logic [CW-1:0] hold_q, hold_d;
  logic [7:0]    switch_q, switch_d;
  logic          sel_q, sel_d;
  logic          timeout, leave_a, leave_b, entry;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    switch_d = switch_q;
    sel_d    = sel_q;

    timeout = (hold_q == HoldMax);
    leave_a = bus.release_i | ~bus.req_a | (timeout & bus.req_b);
    leave_b = bus.release_i | ~bus.req_b | (timeout & bus.req_a);

    unique case (state_q)
      StIdle: begin
        if (bus.req_a && bus.req_b) state_d = last_q ? StGntA : StGntB;
        else if (bus.req_a)         state_d = StGntA;
        else if (bus.req_b)         state_d = StGntB;
      end
      // Hand over directly when the other side is waiting; no idle bubble.
      StGntA: if (leave_a) state_d = bus.req_b ? StGntB : StIdle;
      StGntB: if (leave_b) state_d = bus.req_a ? StGntA : StIdle;
      default: state_d = StIdle;
    endcase

    entry = (state_d != StIdle) && (state_d != state_q);

    if (state_d == StIdle)   hold_d = '0;
    else if (entry)          hold_d = '0;
    else if (!timeout)       hold_d = hold_q + CW'(1);

    if (entry) begin
      switch_d = switch_q + 8'd1;
      last_d   = (state_d == StGntB);
    end

    unique case (state_d)
      StGntA:  sel_d = 1'b0;
      StGntB:  sel_d = 1'b1;
`ifdef STICKY_SEL_EN
      default: sel_d = sel_q;
`else
      default: sel_d = 1'b0;
`endif
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      hold_q   <= '0;
      switch_q <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      switch_q <= switch_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    bus.gnt_a      = (state_q == StGntA);
    bus.gnt_b      = (state_q == StGntB);
    bus.sel        = sel_q;
    bus.hold_cnt   = hold_q;
    bus.switch_cnt = switch_q;
  end

endmodule
